// File: rtl/arduino_addr_rx.sv
// Receives 3-byte address frames from an Arduino over a strobed 8-bit bus.
// The strobe is synchronized, and the first byte carries addr[19:16] in its low nibble.
module arduino_addr_rx #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ard_data,
    input  logic        ard_strobe,
    output logic        ard_ack,
    output logic [19:0] addr_out,
    output logic        addr_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT0 = 2'd1,
        GOT1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_hist;
    logic            r_ack;
    logic            r_valid;
    logic            r_err;
    logic [19:0]     r_addr_out;
    logic [3:0]      r_addr_hi;
    logic [7:0]      r_addr_mid;
    logic [CW-1:0]   r_cnt;
    logic            w_byte_ev;
    logic            w_timeout;
    logic            w_frame_done;
    logic            w_err_next;

    assign w_byte_ev = r_sync2 & ~r_hist;
    // Fires on the edge where the counter would reach TIMEOUT_CYCLES.
    assign w_timeout = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= ard_strobe;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A byte event always takes priority over a timeout expiring in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_byte_ev) begin
                    if (ard_data[7:4] == 4'h0) begin
                        w_state_next = GOT0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            GOT0: begin
                if (w_byte_ev) begin
                    w_state_next = GOT1;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            GOT1: begin
                if (w_byte_ev) begin
                    w_state_next = IDLE;
                    w_frame_done = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                    w_err_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE || w_byte_ev) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_hi  <= 4'h0;
            r_addr_mid <= 8'h00;
        end else if (w_byte_ev && r_state == IDLE && ard_data[7:4] == 4'h0) begin
            r_addr_hi <= ard_data[3:0];
        end else if (w_byte_ev && r_state == GOT0) begin
            r_addr_mid <= ard_data;
        end else if (w_timeout && !w_byte_ev) begin
            r_addr_hi  <= 4'h0;
            r_addr_mid <= 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_out <= 20'h00000;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_addr_out <= {r_addr_hi, r_addr_mid, ard_data};
            end
            r_valid <= w_frame_done;
            r_err   <= w_err_next;
            // Ack acknowledges every sampled byte, including rejected ones.
            if (w_byte_ev) begin
                r_ack <= 1'b1;
            end else if (!r_sync2) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign ard_ack    = r_ack;
    assign addr_out   = r_addr_out;
    assign addr_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: doc/arduino_addr_rx.md
ARDUINO_ADDR_RX -- requirements
Module: arduino_addr_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, max clk cycles allowed between consecutive bytes of one frame.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port ard_data, input, 8, byte from Arduino; stable while ard_strobe high.
REQ-005 SHALL have port ard_strobe, input, 1, asynchronous byte strobe from Arduino; one byte per rising edge.
REQ-006 SHALL have port ard_ack, output, 1, byte-accepted handshake back to Arduino.
REQ-007 SHALL have port addr_out, output, 20, last complete assembled address; feeds the downstream address register.
REQ-008 SHALL have port addr_valid, output, 1, one-cycle pulse when addr_out has just been updated.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a discarded frame.
REQ-010 SHALL have port busy, output, 1, high while a frame is partially received.

Function
REQ-011 SHALL pass ard_strobe through a 2-flop synchronizer plus one history flop; a byte event SHALL be declared on the cycle where sync2=1 and hist=0.
REQ-012 SHALL sample ard_data on the byte-event cycle only; no other cycle captures data.
REQ-013 SHALL use an FSM with states IDLE (expect byte0), GOT0 (expect byte1), GOT1 (expect byte2).
REQ-014 IDLE + byte event with ard_data[7:4]==0: store ard_data[3:0] as addr[19:16], go to GOT0.
REQ-015 IDLE + byte event with ard_data[7:4]!=0: discard, pulse frame_err next cycle, stay IDLE.
REQ-016 GOT0 + byte event: store ard_data as addr[15:8], go to GOT1.
REQ-017 GOT1 + byte event: store ard_data as addr[7:0], go to IDLE; on the next clock edge load addr_out with the full 20-bit value and assert addr_valid for exactly one cycle.
REQ-018 addr_out SHALL hold its value between frames and SHALL NOT change on errored or timed-out frames.
REQ-019 A timeout counter SHALL clear on entering GOT0 and on each byte event, increment every cycle in GOT0/GOT1, and never run in IDLE.
REQ-020 When the counter reaches TIMEOUT_CYCLES in GOT0/GOT1: return to IDLE, discard partial bytes, pulse frame_err for one cycle.
REQ-021 Byte event and timeout expiry in the same cycle: the byte event SHALL win (byte accepted, no frame_err).
REQ-022 ard_ack SHALL rise the cycle after a byte event (including discarded bytes) and fall the cycle after sync2 returns to 0.
REQ-023 busy SHALL equal 1 exactly when state is GOT0 or GOT1.
REQ-024 Byte-event to addr_valid latency SHALL be 1 cycle for byte2; strobe pin edge to byte event SHALL be 2-3 cycles.

Reset
REQ-025 rst high SHALL force state=IDLE, synchronizer/history flops=0, counter=0, addr_out=20'h00000, addr_valid=0, frame_err=0, ard_ack=0, busy=0, regardless of the clock.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; the first byte event after release is treated as byte0.

Verification
REQ-027 Bytes 0x0A, 0xBC, 0xDE with well-spaced strobes -> addr_out=20'hABCDE, addr_valid single pulse 1 cycle after the third byte event, frame_err never high.
REQ-028 Byte 0x3A in IDLE -> frame_err one pulse, busy stays 0, addr_out unchanged, ard_ack still handshakes.
REQ-029 TIMEOUT_CYCLES=16; bytes 0x01, 0x23 then silence -> frame_err pulse 16 cycles after second byte event, busy falls; then 0x04, 0x56, 0x78 -> addr_out=20'h45678.
REQ-030 Third byte event coincident with counter reaching TIMEOUT_CYCLES -> frame accepted, addr_valid pulses, no frame_err.
REQ-031 rst pulse after bytes 0x0F, 0xFF -> busy=0, addr_out=0; then 0x01, 0x02, 0x03 -> addr_out=20'h10203.
REQ-032 Strobe held high for 50 cycles per byte -> exactly one byte event per strobe; ard_ack high until 1 cycle after synchronized strobe low.
